// File: rtl/ysyx_22051468_alu_issue_buf.sv
// ysyx_22051468_alu_issue_buf
// Registered issue stage in front of the 64-bit ALU. It uses a two-entry skid
// buffer (main + skid). The head entry is always the main register, so the
// ALU sees operands one cycle after capture, and the buffer sustains one op
// per cycle. in_ready depends only on buffer state, so there is no
// combinational path from out_ready.
// Build option: define YSYX_22051468_ALU_WPREP_EN to pre-condition RV64 *W
// operands before capture. It zero-extends op_1 for SRLW and sign-extends it
// otherwise. It reduces op_2 to a 5-bit shamt for shifts and sign-extends it
// otherwise.
// Opcode bit positions follow the INST_TYPE ordering: ADD=0, SUB=1, SLL=2,
// SRL=3, SRA=4.
module ysyx_22051468_alu_issue_buf #(
  parameter int WIDTH            = 64,
  parameter int ALU_OPCODE_WIDTH = 9,
  parameter int RD_WIDTH         = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_op_1,
  input  logic [WIDTH-1:0]            in_op_2,
  input  logic [ALU_OPCODE_WIDTH-1:0] in_opcode,
  input  logic                        in_is_U,
  input  logic                        in_is_W,
  input  logic [RD_WIDTH-1:0]         in_rd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_ena,
  output logic [WIDTH-1:0]            out_op_1,
  output logic [WIDTH-1:0]            out_op_2,
  output logic [ALU_OPCODE_WIDTH-1:0] out_opcode,
  output logic                        out_is_U,
  output logic                        out_is_W,
  output logic [RD_WIDTH-1:0]         out_rd
);

  typedef struct packed {
    logic [WIDTH-1:0]            op_1;
    logic [WIDTH-1:0]            op_2;
    logic [ALU_OPCODE_WIDTH-1:0] opcode;
    logic                        is_U;
    logic                        is_W;
    logic [RD_WIDTH-1:0]         rd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  entry_t main_q;
  entry_t skid_q;
  entry_t cap_d;
  logic   in_fire;
  logic   out_fire;

`ifdef YSYX_22051468_ALU_WPREP_EN
  localparam int OP_SLL = 2;
  localparam int OP_SRL = 3;
  localparam int OP_SRA = 4;

  function automatic logic [WIDTH-1:0] sext32(input logic [WIDTH-1:0] v);
    return {{(WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [WIDTH-1:0] zext32(input logic [WIDTH-1:0] v);
    return {{(WIDTH-32){1'b0}}, v[31:0]};
  endfunction

  function automatic logic [WIDTH-1:0] shamt5(input logic [WIDTH-1:0] v);
    return {{(WIDTH-5){1'b0}}, v[4:0]};
  endfunction
`endif

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_ena   = out_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Assemble the entry to capture, applying word-op operand conditioning when enabled
  always_comb begin
    cap_d.op_1   = in_op_1;
    cap_d.op_2   = in_op_2;
    cap_d.opcode = in_opcode;
    cap_d.is_U   = in_is_U;
    cap_d.is_W   = in_is_W;
    cap_d.rd     = in_rd;
`ifdef YSYX_22051468_ALU_WPREP_EN
    if (in_is_W) begin
      cap_d.op_1 = in_opcode[OP_SRL] ? zext32(in_op_1) : sext32(in_op_1);
      cap_d.op_2 = (in_opcode[OP_SLL] | in_opcode[OP_SRL] | in_opcode[OP_SRA])
                   ? shamt5(in_op_2) : sext32(in_op_2);
    end
`endif
  end

  // Buffer occupancy FSM; rst beats flush, flush beats both fires; skid data is never reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_q  <= cap_d;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= cap_d;
          end else if (in_fire) begin
            skid_q  <= cap_d;
            state_q <= FULL;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_op_1   = main_q.op_1;
  assign out_op_2   = main_q.op_2;
  assign out_opcode = main_q.opcode;
  assign out_is_U   = main_q.is_U;
  assign out_is_W   = main_q.is_W;
  assign out_rd     = main_q.rd;

endmodule

// File: tb/tb_ysyx_22051468_alu_issue_buf.sv
// Directed and scoreboarded bench for ysyx_22051468_alu_issue_buf.
// Honours YSYX_22051468_ALU_WPREP_EN when picking word-op expectations.
module tb_ysyx_22051468_alu_issue_buf;

  localparam int W  = 64;
  localparam int OW = 9;
  localparam int RW = 5;
  localparam logic [OW-1:0] OPC_ADD = 9'b0_0000_0001;
  localparam logic [OW-1:0] OPC_SRL = 9'b0_0000_1000;
  localparam logic [OW-1:0] OPC_SRA = 9'b0_0001_0000;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, out_ena;
  logic [W-1:0]  in_op_1, in_op_2, out_op_1, out_op_2;
  logic [OW-1:0] in_opcode, out_opcode;
  logic          in_is_U, in_is_W, out_is_U, out_is_W;
  logic [RW-1:0] in_rd, out_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22051468_alu_issue_buf #(.WIDTH(W), .ALU_OPCODE_WIDTH(OW), .RD_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_1(in_op_1), .in_op_2(in_op_2), .in_opcode(in_opcode),
    .in_is_U(in_is_U), .in_is_W(in_is_W), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ena(out_ena),
    .out_op_1(out_op_1), .out_op_2(out_op_2), .out_opcode(out_opcode),
    .out_is_U(out_is_U), .out_is_W(out_is_W), .out_rd(out_rd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [OW-1:0] opc, input logic u, input logic w,
                          input logic [RW-1:0] rd);
    in_valid = v; in_op_1 = a; in_op_2 = b; in_opcode = opc;
    in_is_U = u; in_is_W = w; in_rd = rd;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] opc;
    logic          u;
    logic          w;
    logic [RW-1:0] rd;
  } op_t;

  op_t sb[$];
  op_t cur, exp_op;
  logic [W-1:0] e1, e2;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b1, 64'd9, 64'd9, OPC_ADD, 1'b0, 1'b0, 5'd1);

    // 1: reset with in_valid held high
    step; step;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ena", {63'd0, out_ena}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_op_1", out_op_1, 64'd0);
    chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    step;
    chk("post_rst_nothing", {63'd0, out_valid}, 64'd0);

    // 2: single op, one-cycle latency
    out_ready = 1'b1;
    drive_in(1'b1, 64'd5, 64'd3, OPC_ADD, 1'b0, 1'b0, 5'd7);
    step;
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_ena", {63'd0, out_ena}, 64'd1);
    chk("single_op1", out_op_1, 64'd5);
    chk("single_op2", out_op_2, 64'd3);
    chk("single_opc", {55'd0, out_opcode}, {55'd0, OPC_ADD});
    chk("single_rd", {59'd0, out_rd}, 64'd7);
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step;
    chk("single_drain", {63'd0, out_valid}, 64'd0);

    // 3: backpressure fills skid, then drains in order
    out_ready = 1'b0;
    drive_in(1'b1, 64'd1, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd1);
    step;
    drive_in(1'b1, 64'd2, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd2);
    step;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    chk("full_head_A", out_op_1, 64'd1);
    drive_in(1'b1, 64'd3, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd3);
    step;
    chk("full_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("full_hold_A", out_op_1, 64'd1);
    chk("full_hold_rd", {59'd0, out_rd}, 64'd1);
    out_ready = 1'b1;
    step;
    chk("drain_B", out_op_1, 64'd2);
    chk("drain_ready", {63'd0, in_ready}, 64'd1);
    step;
    chk("drain_C", out_op_1, 64'd3);
    chk("drain_C_valid", {63'd0, out_valid}, 64'd1);
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step;
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

    // 4: flush from FULL with a simultaneous input
    out_ready = 1'b0;
    drive_in(1'b1, 64'd10, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd10);
    step;
    drive_in(1'b1, 64'd11, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd11);
    step;
    drive_in(1'b1, 64'd12, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd12);
    flush = 1'b1;
    step;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
    flush = 1'b0;
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    step; step;
    chk("flush_nothing_emerges", {63'd0, out_valid}, 64'd0);
    // flush beats in_fire in EMPTY
    drive_in(1'b1, 64'd13, 64'd0, OPC_ADD, 1'b0, 1'b0, 5'd13);
    flush = 1'b1;
    step;
    chk("flush_drops_input", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);

    // reset mid-operation discards a held entry
    out_ready = 1'b0;
    drive_in(1'b1, 64'd20, 64'd21, OPC_ADD, 1'b1, 1'b0, 5'd20);
    step;
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_op1", out_op_1, 64'd0);
    chk("midrst_isU", {63'd0, out_is_U}, 64'd0);

    // 5: word-op operand conditioning
    out_ready = 1'b1;
    drive_in(1'b1, 64'h0000_0000_8000_0000, 64'h3F, OPC_SRA, 1'b0, 1'b1, 5'd4);
    step;
`ifdef YSYX_22051468_ALU_WPREP_EN
    e1 = 64'hFFFF_FFFF_8000_0000; e2 = 64'h1F;
`else
    e1 = 64'h0000_0000_8000_0000; e2 = 64'h3F;
`endif
    chk("sraw_op1", out_op_1, e1);
    chk("sraw_op2", out_op_2, e2);
    chk("sraw_isW", {63'd0, out_is_W}, 64'd1);
    drive_in(1'b1, 64'h0000_0000_8000_0000, 64'h3F, OPC_SRL, 1'b0, 1'b1, 5'd4);
    step;
`ifdef YSYX_22051468_ALU_WPREP_EN
    e1 = 64'h0000_0000_8000_0000; e2 = 64'h1F;
`else
    e1 = 64'h0000_0000_8000_0000; e2 = 64'h3F;
`endif
    chk("srlw_op1", out_op_1, e1);
    chk("srlw_op2", out_op_2, e2);
    drive_in(1'b1, 64'h0000_0001_0000_0001, 64'h1234_5678_FFFF_FFFE, OPC_ADD, 1'b0, 1'b1, 5'd5);
    step;
`ifdef YSYX_22051468_ALU_WPREP_EN
    e1 = 64'h0000_0000_0000_0001; e2 = 64'hFFFF_FFFF_FFFF_FFFE;
`else
    e1 = 64'h0000_0001_0000_0001; e2 = 64'h1234_5678_FFFF_FFFE;
`endif
    chk("addw_op1", out_op_1, e1);
    chk("addw_op2", out_op_2, e2);
    drive_in(1'b1, 64'h0000_0000_8000_0000, 64'h3F, OPC_SRA, 1'b0, 1'b0, 5'd6);
    step;
    chk("sra64_op1", out_op_1, 64'h0000_0000_8000_0000);
    chk("sra64_op2", out_op_2, 64'h3F);
    drive_in(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    step;

    // 6: random stream against a FIFO scoreboard
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic holding = 1'b0;
      while (got < 100 && cyc < 3000) begin
        if (!holding && sent < 100 && $urandom_range(0, 3) != 0) begin
          cur.a = {$urandom, $urandom};
          cur.b = {$urandom, $urandom};
          cur.opc = OW'(1) << $urandom_range(0, OW - 1);
          cur.u = 1'($urandom);
          cur.w = 1'b0;
          cur.rd = RW'($urandom);
          holding = 1'b1;
        end
        drive_in(holding, cur.a, cur.b, cur.opc, cur.u, cur.w, cur.rd);
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("stream_spurious", {63'd0, out_valid}, 64'd0);
          end else begin
            exp_op = sb.pop_front();
            chk("stream_op1", out_op_1, exp_op.a);
            chk("stream_op2", out_op_2, exp_op.b);
            chk("stream_ctl", {48'd0, out_opcode, out_is_U, out_is_W, out_rd},
                {48'd0, exp_op.opc, exp_op.u, exp_op.w, exp_op.rd});
          end
          got++;
        end
        if (holding && in_ready) begin
          sb.push_back(cur);
          sent++;
          holding = 1'b0;
        end
        step;
        cyc++;
      end
      chk("stream_received", 64'(got), 64'd100);
      chk("stream_sb_empty", 64'(sb.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
